// File: rtl/octave_ctrl.sv
// octave_ctrl: takes two raw octave keys, synchronizes and debounces them, then steps a
// saturating octave index and offers each new value to the tone generator until it acks.
module octave_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int OCT_MAX         = 4,
    parameter int OCT_RESET       = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       octave_key_up,
    input  logic       octave_key_down,
    input  logic       octave_ack,
    output logic [2:0] octave,
    output logic       octave_req,
    output logic       busy,
    output logic       at_min,
    output logic       at_max
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_nx;
    logic [2:0] octave_nx, up_val, dn_val, tgt;
    logic [1:0] keys, s1, s2, db, prev, ev;
    logic [CW-1:0] cnt [2];
    assign keys = {octave_key_down, octave_key_up};
    assign ev = db & ~prev;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1     <= '0;
            s2     <= '0;
            db     <= '0;
            prev   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
            state  <= IDLE;
            octave <= 3'(OCT_RESET);
        end else begin
            s1   <= keys;
            s2   <= s1;
            prev <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
            state  <= state_nx;
            octave <= octave_nx;
        end
    end
    // simultaneous up/down events leave tgt equal to octave, so they are dropped
    always_comb begin
        up_val    = (octave == 3'(OCT_MAX)) ? octave : octave + 3'd1;
        dn_val    = (octave == 3'd0) ? octave : octave - 3'd1;
        tgt       = (ev == 2'b01) ? up_val : (ev == 2'b10) ? dn_val : octave;
        state_nx  = state;
        octave_nx = octave;
        if (state == IDLE) begin
            octave_nx = tgt;
            state_nx  = (tgt != octave) ? REQ : IDLE;
        end else state_nx = octave_ack ? IDLE : REQ;
    end
    assign octave_req = (state == REQ);
    assign busy       = (state == REQ);
    assign at_min     = (octave == 3'd0);
    assign at_max     = (octave == 3'(OCT_MAX));
endmodule

// File: tb/tb_octave_ctrl.sv
// tb_octave_ctrl: directed scenario tests for octave_ctrl with DEBOUNCE_CYCLES=4, OCT_MAX=4.
module tb_octave_ctrl;
    logic clk = 1'b0;
    logic n_rst, up, down, ack;
    logic [2:0] octave;
    logic octave_req, busy, at_min, at_max;
    int errors = 0;
    int checks = 0;

    octave_ctrl #(.DEBOUNCE_CYCLES(4), .OCT_MAX(4), .OCT_RESET(0)) dut (
        .clk(clk), .n_rst(n_rst), .octave_key_up(up), .octave_key_down(down),
        .octave_ack(ack), .octave(octave), .octave_req(octave_req), .busy(busy),
        .at_min(at_min), .at_max(at_max)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        up = 1'b0;
        down = 1'b0;
        ack = 1'b0;
        step(2);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (octave !== 3'd0) begin errors++; $display("FAIL reset_octave got=%0d exp=0", octave); end
        checks++;
        if (octave_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_req got=%b/%b exp=0/0", octave_req, busy); end
        checks++;
        if (at_min !== 1'b1 || at_max !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b/%b exp=1/0", at_min, at_max); end
    endtask

    task automatic test_latency();
        do_reset();
        up = 1'b1;
        step(6);
        checks++;
        if (octave !== 3'd0 || octave_req !== 1'b0) begin errors++; $display("FAIL lat_early got=%0d/%b exp=0/0", octave, octave_req); end
        step();
        checks++;
        if (octave !== 3'd1 || octave_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL lat_edge7 got=%0d/%b/%b exp=1/1/1", octave, octave_req, busy); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (octave_req !== 1'b0 || octave !== 3'd1) begin errors++; $display("FAIL lat_ack got=%0d/%b exp=1/0", octave, octave_req); end
        step(12);
        checks++;
        if (octave !== 3'd1 || octave_req !== 1'b0) begin errors++; $display("FAIL lat_held got=%0d/%b exp=1/0", octave, octave_req); end
        up = 1'b0;
        step(8);
    endtask

    task automatic test_glitch();
        do_reset();
        up = 1'b1;
        step(3);
        up = 1'b0;
        step(12);
        checks++;
        if (octave !== 3'd0 || octave_req !== 1'b0) begin errors++; $display("FAIL glitch got=%0d/%b exp=0/0", octave, octave_req); end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_oct;
        logic exp_req;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            exp_oct = (i > 4) ? 3'd4 : 3'(i);
            exp_req = (i < 5);
            up = 1'b1;
            step(7);
            checks++;
            if (octave !== exp_oct || octave_req !== exp_req) begin errors++; $display("FAIL sat_press%0d got=%0d/%b exp=%0d/%b", i, octave, octave_req, exp_oct, exp_req); end
            if (exp_req) begin
                ack = 1'b1;
                step();
                ack = 1'b0;
            end
            up = 1'b0;
            step(8);
        end
        checks++;
        if (at_max !== 1'b1 || at_min !== 1'b0) begin errors++; $display("FAIL sat_at_max got=%b/%b exp=1/0", at_max, at_min); end
        do_reset();
        down = 1'b1;
        step(7);
        checks++;
        if (octave !== 3'd0 || octave_req !== 1'b0 || at_min !== 1'b1) begin errors++; $display("FAIL sat_down_min got=%0d/%b/%b exp=0/0/1", octave, octave_req, at_min); end
        down = 1'b0;
        step(8);
    endtask

    task automatic test_conflict();
        do_reset();
        up = 1'b1;
        down = 1'b1;
        step(10);
        checks++;
        if (octave !== 3'd0 || octave_req !== 1'b0) begin errors++; $display("FAIL both_keys got=%0d/%b exp=0/0", octave, octave_req); end
        up = 1'b0;
        down = 1'b0;
        step(8);
        up = 1'b1;
        step(7);
        checks++;
        if (octave !== 3'd1 || octave_req !== 1'b1) begin errors++; $display("FAIL req_first got=%0d/%b exp=1/1", octave, octave_req); end
        up = 1'b0;
        step(8);
        up = 1'b1;
        step(7);
        checks++;
        if (octave !== 3'd1 || octave_req !== 1'b1) begin errors++; $display("FAIL req_discard got=%0d/%b exp=1/1", octave, octave_req); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step(5);
        checks++;
        if (octave !== 3'd1 || octave_req !== 1'b0) begin errors++; $display("FAIL req_after_ack got=%0d/%b exp=1/0", octave, octave_req); end
        up = 1'b0;
        step(8);
    endtask

    task automatic test_reset_in_req();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            up = 1'b1;
            step(7);
            if (i < 3) begin
                ack = 1'b1;
                step();
                ack = 1'b0;
            end
            up = 1'b0;
            step(8);
        end
        checks++;
        if (octave !== 3'd3 || octave_req !== 1'b1) begin errors++; $display("FAIL pre_rst got=%0d/%b exp=3/1", octave, octave_req); end
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        checks++;
        if (octave !== 3'd0 || octave_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_in_req got=%0d/%b/%b exp=0/0/0", octave, octave_req, busy); end
    endtask

    task automatic test_held_through_reset();
        n_rst = 1'b0;
        up = 1'b1;
        step(2);
        n_rst = 1'b1;
        step(6);
        checks++;
        if (octave !== 3'd0 || octave_req !== 1'b0) begin errors++; $display("FAIL held_rst_early got=%0d/%b exp=0/0", octave, octave_req); end
        step();
        checks++;
        if (octave !== 3'd1 || octave_req !== 1'b1) begin errors++; $display("FAIL held_rst_press got=%0d/%b exp=1/1", octave, octave_req); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        up = 1'b0;
        step(8);
    endtask

    task automatic test_ack_idle();
        do_reset();
        up = 1'b1;
        step(7);
        ack = 1'b1;
        step();
        ack = 1'b0;
        up = 1'b0;
        step(8);
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (octave !== 3'd1 || octave_req !== 1'b0 || busy !== 1'b0 || at_min !== 1'b0 || at_max !== 1'b0) begin
                errors++;
                $display("FAIL ack_idle%0d got=%0d/%b/%b/%b/%b exp=1/0/0/0/0", i, octave, octave_req, busy, at_min, at_max);
            end
        end
        ack = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        up = 1'b0;
        down = 1'b0;
        ack = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_saturation();
        test_conflict();
        test_reset_in_req();
        test_held_through_reset();
        test_ack_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
